// File: rtl/alu16_pkg.sv
// Shared widths, opcodes, sequencer state encoding and the captured-result payload
// for the ALU16 issue/capture wrapper.
package alu16_pkg;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned CTRL_W  = 4;
   localparam int unsigned NUM_OPS = 8;

   localparam logic [CTRL_W-1:0] OP_AND  = 4'd0;
   localparam logic [CTRL_W-1:0] OP_OR   = 4'd1;
   localparam logic [CTRL_W-1:0] OP_ADD  = 4'd2;
   localparam logic [CTRL_W-1:0] OP_SUB  = 4'd3;
   localparam logic [CTRL_W-1:0] OP_NOTA = 4'd4;
   localparam logic [CTRL_W-1:0] OP_NOTB = 4'd5;
   localparam logic [CTRL_W-1:0] OP_INC  = 4'd6;
   localparam logic [CTRL_W-1:0] OP_DEC  = 4'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             overflow;
      logic             zero;
      logic             illegal;
   } result_t;

   function automatic logic is_legal(input logic [CTRL_W-1:0] op);
      return 32'(op) < NUM_OPS;
   endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU: logic ops plus add/sub/inc/dec with signed overflow.
module alu16
   import alu16_pkg::*;
(
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [CTRL_W-1:0] alu_ctrl,
   output logic [WIDTH-1:0]  s,
   output logic              overflow,
   output logic              zero
);

   localparam int unsigned MSB = WIDTH - 1;

   always_comb begin
      s        = '0;
      overflow = 1'b0;
      case (alu_ctrl)
         OP_AND:  s = a & b;
         OP_OR:   s = a | b;
         OP_ADD: begin
            s        = a + b;
            overflow = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
         end
         OP_SUB: begin
            s        = a - b;
            overflow = (a[MSB] != b[MSB]) && (s[MSB] != a[MSB]);
         end
         OP_NOTA: s = ~a;
         OP_NOTB: s = ~b;
         OP_INC: begin
            s        = a + WIDTH'(1);
            overflow = !a[MSB] && s[MSB];
         end
         OP_DEC: begin
            s        = a - WIDTH'(1);
            overflow = a[MSB] && !s[MSB];
         end
         default: s = '0;
      endcase
      zero = (s == '0);
   end

endmodule

// File: rtl/alu16_result_hold.sv
// Result side of the sequencer: holds the captured result until consumed, and keeps
// the sticky overflow flag and the consumed-op counter.
module alu16_result_hold
   import alu16_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  result_t          res,
   input  logic             out_ready,
   input  logic             clr_sticky,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_s,
   output logic             out_overflow,
   output logic             out_zero,
   output logic             out_illegal,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] op_count
);

   logic consume;

   assign consume = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_s        <= '0;
         out_overflow <= 1'b0;
         out_zero     <= 1'b0;
         out_illegal  <= 1'b0;
         sticky_ovf   <= 1'b0;
         op_count     <= '0;
      end else begin
         if (capture) begin
            out_valid    <= 1'b1;
            out_s        <= res.s;
            out_overflow <= res.overflow;
            out_zero     <= res.zero;
            out_illegal  <= res.illegal;
         end else if (consume) begin
            out_valid <= 1'b0;
         end
         if (consume) begin
            op_count <= op_count + CNT_W'(1);
         end
         // A consumed overflow beats a simultaneous clear.
         if (consume && out_overflow) begin
            sticky_ovf <= 1'b1;
         end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu16_op_sequencer.sv
// Issue/capture stage around ALU16: accepts one op per handshake, drives registered
// operands to the ALU, and captures its outputs one cycle later.
module alu16_op_sequencer
   import alu16_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]  alu_s,
   input  logic              alu_overflow,
   input  logic              alu_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_s,
   output logic              out_overflow,
   output logic              out_zero,
   output logic              out_illegal,
   output logic              sticky_ovf,
   input  logic              clr_sticky,
   output logic [CNT_W-1:0]  op_count
);

   state_t  state, state_nxt;
   logic    accept;
   result_t res;

   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = EXEC;
         EXEC: state_nxt = HOLD;
         HOLD: if (out_ready) state_nxt = accept ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operands only move on an accept edge, so the ALU sees stable inputs otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= '0;
      end else if (accept) begin
         alu_a    <= in_a;
         alu_b    <= in_b;
         alu_ctrl <= in_ctrl;
      end
   end

   always_comb begin
      res.s        = alu_s;
      res.overflow = alu_overflow;
      res.zero     = alu_zero;
      res.illegal  = 1'b0;
      if (!is_legal(alu_ctrl)) begin
         res.s        = '0;
         res.overflow = 1'b0;
         res.zero     = 1'b0;
         res.illegal  = 1'b1;
      end
   end

   alu16_result_hold #(.CNT_W(CNT_W)) u_hold (
      .clk          (clk),
      .rst          (rst),
      .capture      (state == EXEC),
      .res          (res),
      .out_ready    (out_ready),
      .clr_sticky   (clr_sticky),
      .out_valid    (out_valid),
      .out_s        (out_s),
      .out_overflow (out_overflow),
      .out_zero     (out_zero),
      .out_illegal  (out_illegal),
      .sticky_ovf   (sticky_ovf),
      .op_count     (op_count)
   );

endmodule

// File: tb/tb_alu16_op_sequencer.sv
// Bench for alu16_op_sequencer with the real ALU16 in the loop: table vectors,
// hand-written corner sequences and random ops checked against an arithmetic model.
module tb_alu16_op_sequencer;
   import alu16_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0, in_b = '0;
   logic [3:0]  in_ctrl = '0;
   logic [15:0] alu_a, alu_b, alu_s;
   logic [3:0]  alu_ctrl;
   logic        alu_overflow, alu_zero;
   logic        out_valid, out_ready = 1'b0;
   logic [15:0] out_s;
   logic        out_overflow, out_zero, out_illegal, sticky_ovf;
   logic        clr_sticky = 1'b0;
   logic [15:0] op_count;

   // narrow-counter instance used only to exercise counter wrap cheaply
   logic        w_rst = 1'b1, w_in_ready, w_out_valid;
   logic [15:0] w_alu_a, w_alu_b, w_out_s;
   logic [3:0]  w_alu_ctrl;
   logic        w_out_overflow, w_out_zero, w_out_illegal, w_sticky;
   logic [3:0]  w_op_count;

   int nvec = 0;
   int nfail = 0;
   int exp_cnt = 0;
   logic exp_sticky = 1'b0;

   always #5 clk = ~clk;

   alu16_op_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_s(alu_s), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
      .out_overflow(out_overflow), .out_zero(out_zero), .out_illegal(out_illegal),
      .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .op_count(op_count)
   );

   alu16 u_alu (
      .a(alu_a), .b(alu_b), .alu_ctrl(alu_ctrl),
      .s(alu_s), .overflow(alu_overflow), .zero(alu_zero)
   );

   alu16_op_sequencer #(.CNT_W(4)) dut_w (
      .clk(clk), .rst(w_rst), .in_valid(1'b1), .in_ready(w_in_ready),
      .in_a(16'h0001), .in_b(16'h0002), .in_ctrl(OP_ADD),
      .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_ctrl(w_alu_ctrl),
      .alu_s(16'h0003), .alu_overflow(1'b0), .alu_zero(1'b0),
      .out_valid(w_out_valid), .out_ready(1'b1), .out_s(w_out_s),
      .out_overflow(w_out_overflow), .out_zero(w_out_zero), .out_illegal(w_out_illegal),
      .sticky_ovf(w_sticky), .clr_sticky(1'b0), .op_count(w_op_count)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  ctrl;
      logic [15:0] s;
      logic        ovf;
      logic        zero;
      logic        ill;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour from the opcode definitions, using signed integer arithmetic.
   task automatic ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [3:0] ctrl,
                          output logic [15:0] s, output logic ovf, output logic zero,
                          output logic ill);
      int sa, sb, r;
      bit arith;
      sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
      sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
      arith = 1'b0;
      r = 0;
      ill = 1'b0;
      case (ctrl)
         4'd0: r = int'(a & b);
         4'd1: r = int'(a | b);
         4'd2: begin r = sa + sb; arith = 1'b1; end
         4'd3: begin r = sa - sb; arith = 1'b1; end
         4'd4: r = int'(~a);
         4'd5: r = int'(~b);
         4'd6: begin r = sa + 1; arith = 1'b1; end
         4'd7: begin r = sa - 1; arith = 1'b1; end
         default: ill = 1'b1;
      endcase
      ovf  = arith && (r > 32767 || r < -32768);
      s    = 16'(r);
      zero = !ill && (s == 16'h0000);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      clr_sticky = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      exp_sticky = 1'b0;
   endtask

   // One op from IDLE: accept, EXEC, hold for `delay` cycles, consume, check side effects.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] ctrl, input logic [15:0] es, input logic eo,
                         input logic ez, input logic ei, input int delay, input logic clr);
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_ctrl = ctrl; out_ready = 1'b0;
      chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_a = ~a; in_b = ~b;
      chk({tag, " valid in exec"}, 32'(out_valid), 32'd0);
      chk({tag, " alu operands"}, {alu_a, alu_b}, {a, b});
      chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(ctrl));
      @(negedge clk);
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " out_s"}, 32'(out_s), 32'(es));
      chk({tag, " flags ovf/zero/ill"}, {29'd0, out_overflow, out_zero, out_illegal},
          {29'd0, eo, ez, ei});
      for (int d = 0; d < delay; d++) begin
         chk({tag, " in_ready while held"}, 32'(in_ready), 32'd0);
         @(negedge clk);
         chk({tag, " held result"}, {12'd0, out_valid, out_s, out_overflow, out_zero, out_illegal},
             {12'd0, 1'b1, es, eo, ez, ei});
      end
      out_ready = 1'b1;
      clr_sticky = clr;
      @(posedge clk);
      exp_cnt = (exp_cnt + 1) % 65536;
      if (eo) exp_sticky = 1'b1;
      else if (clr) exp_sticky = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      clr_sticky = 1'b0;
      chk({tag, " valid after consume"}, 32'(out_valid), 32'd0);
      chk({tag, " op_count"}, 32'(op_count), 32'(exp_cnt));
      chk({tag, " sticky_ovf"}, 32'(sticky_ovf), 32'(exp_sticky));
   endtask

   vec_t tbl[12];

   initial begin
      logic [15:0] es, ra, rb;
      logic        eo, ez, ei, prev_acc, acc;
      int          got, last, next_a, wcnt;
      logic [3:0]  rc;
      logic [15:0] edge_vals[4];

      tbl[0]  = '{16'hF0F0, 16'h3C3C, OP_AND,  16'h3030, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{16'hF0F0, 16'h0F0F, OP_OR,   16'hFFFF, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{16'h7FFF, 16'h0001, OP_ADD,  16'h8000, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{16'h1234, 16'h1234, OP_SUB,  16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{16'h00FF, 16'h1234, OP_NOTA, 16'hFF00, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{16'h1234, 16'hFFFF, OP_NOTB, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{16'hFFFF, 16'h0000, OP_INC,  16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{16'h8000, 16'h0000, OP_DEC,  16'h7FFF, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{16'h8000, 16'h0001, OP_SUB,  16'h7FFF, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{16'h0005, 16'h0003, 4'hF,    16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{16'hFFFF, 16'h0001, OP_ADD,  16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{16'h7FFF, 16'hFFFF, 4'h8,    16'h0000, 1'b0, 1'b0, 1'b1};
      edge_vals[0] = 16'h0000; edge_vals[1] = 16'h7FFF;
      edge_vals[2] = 16'h8000; edge_vals[3] = 16'hFFFF;

      // reset state
      do_reset();
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset outputs", {8'd0, out_valid, out_s, out_overflow, out_zero, out_illegal, sticky_ovf},
          32'd0);
      chk("reset op_count", 32'(op_count), 32'd0);

      // async reset while EXEC, after leaving nonzero history behind
      run_op("pre-reset ovf", 16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'h0005; in_b = 16'h0003; in_ctrl = OP_ADD;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midexec rst in_ready", 32'(in_ready), 32'd1);
      chk("midexec rst alu regs", {alu_a, alu_b}, 32'd0);
      chk("midexec rst outputs", {8'd0, out_valid, out_s, out_overflow, out_zero, out_illegal,
          sticky_ovf}, 32'd0);
      chk("midexec rst op_count", 32'(op_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0; exp_sticky = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("no result after rst", 32'(out_valid), 32'd0);

      // table vectors, with one long hold on the SUB zero case
      do_reset();
      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ctrl, tbl[i].s,
                tbl[i].ovf, tbl[i].zero, tbl[i].ill, (i == 3) ? 5 : 0, 1'b0);
      end

      // overflow consumed with clr_sticky on the same edge: set wins, then clear alone
      do_reset();
      run_op("sticky set wins", 16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
      @(negedge clk);
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
      exp_sticky = 1'b0;
      chk("sticky cleared", 32'(sticky_ovf), 32'd0);

      // back-to-back stream of INC on 0..19
      do_reset();
      in_ctrl = OP_INC; in_b = 16'h0; in_a = 16'h0; in_valid = 1'b1; out_ready = 1'b1;
      next_a = 0; got = 0; last = -1; prev_acc = 1'b0;
      for (int cyc = 0; cyc < 120 && got < 20; cyc++) begin
         if (cyc != 0) @(negedge clk);
         if (prev_acc) begin
            next_a++;
            if (next_a >= 20) in_valid = 1'b0;
            else in_a = 16'(next_a);
         end
         if (out_valid) begin
            chk("stream out_s", 32'(out_s), 32'(got + 1));
            if (last >= 0) chk("stream spacing", 32'(cyc - last), 32'd2);
            last = cyc;
            got++;
         end
         acc = in_valid && in_ready;
         prev_acc = acc;
      end
      if (got < 20) chk("stream timeout results", 32'(got), 32'd20);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      chk("stream op_count", 32'(op_count), 32'd20);
      exp_cnt = 20;

      // random ops against the model
      do_reset();
      for (int i = 0; i < 150; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
         rc = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         ref_alu(ra, rb, rc, es, eo, ez, ei);
         run_op($sformatf("rnd%0d", i), ra, rb, rc, es, eo, ez, ei,
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      end

      // counter wrap on the 4-bit instance: 20 consumes, count modulo 16
      @(negedge clk);
      w_rst = 1'b0;
      wcnt = 0; got = 0; prev_acc = 1'b0;
      for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
         @(negedge clk);
         if (prev_acc) begin
            wcnt = (wcnt + 1) % 16;
            got++;
            chk("wrap op_count", 32'(w_op_count), 32'(wcnt));
         end
         prev_acc = w_out_valid;
      end
      if (got < 20) chk("wrap timeout consumes", 32'(got), 32'd20);
      w_rst = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
